axi4lite_regbank: RTL and testbench
===================================

Name: axi4lite_regbank

Overview:
Parametrised AXI4-Lite slave register bank that replaces hand-written per-block register decoders. It holds NUM_REGS read/write control registers, with per-register read-only override from status inputs. It supports independent AW/W arrival, byte strobes and SLVERR decoding. It sits behind the AXI4-Lite interconnect and drives control/status fields of peripheral blocks.

Parameters:
DATA_WIDTH, 32, bus data width; 32 or 64 only.
ADDR_WIDTH, 32, bus address width.
NUM_REGS, 16, number of word registers; 1..256.
RO_MASK, {NUM_REGS{1'b0}}, bit i=1: register i is read-only and reads status_in word i.

Ports:
axi_aclk  in  1  bus clock; all logic on rising edge
axi_aresetn  in  1  asynchronous active-low reset
axi_awaddr  in  ADDR_WIDTH  write address
axi_awvalid  in  1  write address valid
axi_awready  out  1  write address ready
axi_wdata  in  DATA_WIDTH  write data
axi_wstrb  in  DATA_WIDTH/8  byte strobes
axi_wvalid  in  1  write data valid
axi_wready  out  1  write data ready
axi_bresp  out  2  write response
axi_bvalid  out  1  write response valid
axi_bready  in  1  write response ready
axi_araddr  in  ADDR_WIDTH  read address
axi_arvalid  in  1  read address valid
axi_arready  out  1  read address ready
axi_rdata  out  DATA_WIDTH  read data
axi_rresp  out  2  read response
axi_rvalid  out  1  read data valid
axi_rready  in  1  read data ready
reg_out  out  NUM_REGS*DATA_WIDTH  register contents; word i at [i*DATA_WIDTH +: DATA_WIDTH]
status_in  in  NUM_REGS*DATA_WIDTH  status words; only RO_MASK words are used
wr_pulse  out  NUM_REGS  one-cycle strobe on successful write to register i

Behaviour:
- Reset: asynchronous on axi_aresetn low. All registers, reg_out, wr_pulse, axi_bvalid, axi_rvalid, axi_bresp, axi_rresp and axi_rdata go to 0. axi_awready, axi_wready and axi_arready are 0 during reset and rise on the first edge after release. Reset mid-transaction discards held address/data and any pending response; no register is written.
- Decode: ADDR_LSB = log2(DATA_WIDTH/8); index = addr >> ADDR_LSB; low ADDR_LSB bits ignored. Address is valid iff index < NUM_REGS.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_COMMIT, W_RESP.
  - W_IDLE: awready=wready=1. AW only -> W_HAVE_ADDR. W only -> W_HAVE_DATA. Both in the same cycle -> W_COMMIT.
  - W_HAVE_ADDR: awready=0, wready=1; W handshake -> W_COMMIT.
  - W_HAVE_DATA: wready=0, awready=1; AW handshake -> W_COMMIT.
  - W_COMMIT: one cycle; both readies 0.
    - Valid, non-RO index: byte k is written iff wstrb[k]; wr_pulse[index]=1 this cycle; bresp=OKAY (2'b00).
    - Out-of-range or RO index: no write, no pulse, bresp=SLVERR (2'b10).
    - bvalid=1 from the next cycle. -> W_RESP.
  - W_RESP: readies 0, bvalid held with bresp stable until bready -> W_IDLE; bvalid drops the cycle after the handshake.
  - Only one write outstanding. AW-to-bvalid latency is 2 cycles minimum.
- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: arready=1. AR handshake -> rdata/rresp registered on the same edge -> R_RESP; rvalid=1 from the next cycle, so AR-to-rvalid latency is 1 cycle.
  - Data source: RO index -> status_in word sampled at the AR edge. Valid RW index -> register value. Out-of-range -> rdata=0, rresp=SLVERR.
  - R_RESP: arready=0; rvalid, rdata and rresp held stable until rready -> R_IDLE.
- Read and write channels are fully independent. A read handshake in the same cycle as a W_COMMIT to the same index returns the pre-write value; a read accepted one cycle later returns the new value.
- reg_out always reflects stored register values, including RO slots, which hold 0 because they are never written.
- wstrb=0 to a valid index: bresp=OKAY, register unchanged, wr_pulse still asserted.

Test Plan:
- Reset release: all outputs 0 during reset; awready/wready/arready=1 one cycle after release; reg_out=0.
- AW and W in the same cycle to 0x8, wdata=0xDEADBEEF, wstrb=0xF -> reg 2=0xDEADBEEF, wr_pulse[2] for one cycle, bvalid 2 cycles after AW with bresp=00; read 0x8 returns 0xDEADBEEF, rresp=00, 1 cycle latency.
- W 3 cycles before AW to 0x4, wdata=0x11223344, wstrb=0x5, reg 1 previously 0xFFFFFFFF -> wready low after the W handshake, reg 1=0xFF22FF44, bresp=00.
- Write/read to index NUM_REGS (0x40 for defaults) and a write to an RO_MASK register -> bresp=10, no wr_pulse, rresp=10 with rdata=0; RO read returns the current status_in word, e.g. 0xA5A5A5A5.
- Backpressure: bready low for 5 cycles -> bvalid and bresp stable, awready=0 throughout; rready low for 4 cycles -> rdata stable, arready=0.
- Assert axi_aresetn low while in W_HAVE_ADDR and while rvalid=1 -> bvalid/rvalid drop immediately, registers return to 0, next transaction completes normally.

Source files
------------

// File: rtl/axi4lite_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS word registers with byte-strobed
// writes, per-register read-only status override and SLVERR on bad targets.
module axi4lite_regbank #(
    parameter int unsigned         DATA_WIDTH = 32,
    parameter int unsigned         ADDR_WIDTH = 32,
    parameter int unsigned         NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = {NUM_REGS{1'b0}}
) (
    input  logic                           axi_aclk,
    input  logic                           axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]          axi_awaddr,
    input  logic                           axi_awvalid,
    output logic                           axi_awready,
    input  logic [DATA_WIDTH-1:0]          axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        axi_wstrb,
    input  logic                           axi_wvalid,
    output logic                           axi_wready,
    output logic [1:0]                     axi_bresp,
    output logic                           axi_bvalid,
    input  logic                           axi_bready,
    input  logic [ADDR_WIDTH-1:0]          axi_araddr,
    input  logic                           axi_arvalid,
    output logic                           axi_arready,
    output logic [DATA_WIDTH-1:0]          axi_rdata,
    output logic [1:0]                     axi_rresp,
    output logic                           axi_rvalid,
    input  logic                           axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_COMMIT,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rstate_t;

    // Word index is in range of the bank
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a >> ADDR_LSB) < ADDR_WIDTH'(NUM_REGS);
    endfunction

    // Word index with the byte-offset bits dropped
    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(a >> ADDR_LSB);
    endfunction

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] status_w;

    wstate_t w_state, w_next;
    rstate_t r_state, r_next;

    logic                  aw_hs, w_hs, ar_hs;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;

    logic                  awready_d, wready_d, bvalid_d, arready_d, rvalid_d;
    logic [1:0]            bresp_d, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [NUM_REGS-1:0]   wr_pulse_d;
    logic [IDX_W-1:0]      widx, ridx;

    assign status_w = status_in;
    assign reg_out  = regs;

    assign aw_hs = axi_awvalid & axi_awready;
    assign w_hs  = axi_wvalid  & axi_wready;
    assign ar_hs = axi_arvalid & axi_arready;

    // Address/data as they will be held once any handshake this cycle lands
    assign awaddr_d = aw_hs ? axi_awaddr : awaddr_q;
    assign wdata_d  = w_hs  ? axi_wdata  : wdata_q;
    assign wstrb_d  = w_hs  ? axi_wstrb  : wstrb_q;
    assign widx     = addr_idx(awaddr_d);
    assign ridx     = addr_idx(axi_araddr);

    // Write and read state registers
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Write next-state: collect AW and W in either order, commit, respond
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) w_next = W_COMMIT;
                else if (aw_hs)    w_next = W_HAVE_ADDR;
                else if (w_hs)     w_next = W_HAVE_DATA;
            end
            W_HAVE_ADDR: if (w_hs)  w_next = W_COMMIT;
            W_HAVE_DATA: if (aw_hs) w_next = W_COMMIT;
            W_COMMIT:    w_next = W_RESP;
            W_RESP:      if (axi_bvalid && axi_bready) w_next = W_IDLE;
            default:     w_next = W_IDLE;
        endcase
    end

    // Read next-state
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_RESP;
            R_RESP:  if (axi_rvalid && axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Output next values; decode is done on entry to W_COMMIT so the pulse
    // is visible during the commit cycle itself
    always_comb begin
        awready_d  = (w_next == W_IDLE) || (w_next == W_HAVE_DATA);
        wready_d   = (w_next == W_IDLE) || (w_next == W_HAVE_ADDR);
        bvalid_d   = (w_next == W_RESP);
        bresp_d    = axi_bresp;
        wr_pulse_d = '0;
        if ((w_state != W_COMMIT) && (w_next == W_COMMIT)) begin
            if (addr_ok(awaddr_d) && !RO_MASK[widx]) begin
                wr_pulse_d[widx] = 1'b1;
                bresp_d          = RESP_OKAY;
            end else begin
                bresp_d          = RESP_SLVERR;
            end
        end

        arready_d = (r_next == R_IDLE);
        rvalid_d  = (r_next == R_RESP);
        rdata_d   = axi_rdata;
        rresp_d   = axi_rresp;
        if (ar_hs) begin
            if (!addr_ok(axi_araddr)) begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end else if (RO_MASK[ridx]) begin
                rdata_d = status_w[ridx];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = regs[ridx];
                rresp_d = RESP_OKAY;
            end
        end
    end

    // Registered bus outputs and write pulse
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            axi_awready <= 1'b0;
            axi_wready  <= 1'b0;
            axi_bvalid  <= 1'b0;
            axi_bresp   <= 2'b00;
            axi_arready <= 1'b0;
            axi_rvalid  <= 1'b0;
            axi_rdata   <= '0;
            axi_rresp   <= 2'b00;
            wr_pulse    <= '0;
        end else begin
            axi_awready <= awready_d;
            axi_wready  <= wready_d;
            axi_bvalid  <= bvalid_d;
            axi_bresp   <= bresp_d;
            axi_arready <= arready_d;
            axi_rvalid  <= rvalid_d;
            axi_rdata   <= rdata_d;
            axi_rresp   <= rresp_d;
            wr_pulse    <= wr_pulse_d;
        end
    end

    // Held write address, data and strobes
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            awaddr_q <= awaddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
        end
    end

    // Register file: byte-strobed update at the end of the commit cycle
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            regs <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_pulse[i] && !RO_MASK[i]) begin
                    for (int unsigned k = 0; k < STRB_W; k++) begin
                        if (wstrb_q[k]) regs[i][k*8 +: 8] <= wdata_q[k*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_regbank.sv
// Directed bench for axi4lite_regbank: vector table plus multi-cycle sequences.
module tb_axi4lite_regbank;

    localparam logic [15:0] RO = 16'h0008;

    logic         clk;
    logic         rst_n;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic [3:0]   wstrb;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [1:0]   bresp, rresp;
    logic [511:0] reg_out, status_in;
    logic [15:0]  wr_pulse;

    int checks   = 0;
    int failures = 0;

    axi4lite_regbank #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16), .RO_MASK(RO)
    ) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
        .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
        .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready),
        .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
        .reg_out(reg_out), .status_in(status_in), .wr_pulse(wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [15:0] pulse;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input int i);
        return reg_out[i*32 +: 32];
    endfunction

    // Simultaneous AW+W write with fixed-latency response checks
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] exp_resp, input logic [15:0] exp_pulse,
                             input string tag);
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (!(awready && wready) && n < 20) begin tick(); n++; end
        chk({tag, "_ready"}, 64'(awready && wready), 64'd1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk({tag, "_pulse"}, 64'(wr_pulse), 64'(exp_pulse));
        chk({tag, "_bvalid_early"}, 64'(bvalid), 64'd0);
        tick();
        chk({tag, "_bvalid"}, 64'(bvalid), 64'd1);
        chk({tag, "_bresp"}, 64'(bresp), 64'(exp_resp));
        chk({tag, "_pulse_off"}, 64'(wr_pulse), 64'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk({tag, "_bvalid_drop"}, 64'(bvalid), 64'd0);
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input string tag);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 20) begin tick(); n++; end
        chk({tag, "_arready"}, 64'(arready), 64'd1);
        tick();
        arvalid = 1'b0;
        chk({tag, "_rvalid"}, 64'(rvalid), 64'd1);
        chk({tag, "_rdata"}, 64'(rdata), 64'(exp_data));
        chk({tag, "_rresp"}, 64'(rresp), 64'(exp_resp));
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk({tag, "_rvalid_drop"}, 64'(rvalid), 64'd0);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0,        16'h0004};
        vecs[1]  = '{1'b0, 32'h08, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 16'h0};
        vecs[2]  = '{1'b1, 32'h04, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h0,        16'h0002};
        vecs[3]  = '{1'b1, 32'h40, 32'h12345678, 4'hF, 2'b10, 32'h0,        16'h0};
        vecs[4]  = '{1'b0, 32'h40, 32'h0,        4'h0, 2'b10, 32'h0,        16'h0};
        vecs[5]  = '{1'b1, 32'h0C, 32'h12345678, 4'hF, 2'b10, 32'h0,        16'h0};
        vecs[6]  = '{1'b0, 32'h0C, 32'h0,        4'h0, 2'b00, 32'hA5A5A5A5, 16'h0};
        vecs[7]  = '{1'b1, 32'h3C, 32'h000000AA, 4'h1, 2'b00, 32'h0,        16'h8000};
        vecs[8]  = '{1'b0, 32'h3F, 32'h0,        4'h0, 2'b00, 32'h000000AA, 16'h0};
        vecs[9]  = '{1'b1, 32'h3C, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0,        16'h8000};
        vecs[10] = '{1'b0, 32'h3C, 32'h0,        4'h0, 2'b00, 32'h000000AA, 16'h0};
        vecs[11] = '{1'b0, 32'h04, 32'h0,        4'h0, 2'b00, 32'hFFFFFFFF, 16'h0};

        rst_n = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        status_in = '0;
        status_in[3*32 +: 32] = 32'hA5A5A5A5;

        // Outputs held low during reset, readies rise one edge after release
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_regout", 64'(reg_out == '0), 64'd1);
        chk("rst_pulse", 64'(wr_pulse), 64'd0);
        rst_n = 1'b1;
        chk("rel_awready_low", 64'(awready), 64'd0);
        tick();
        chk("rel_awready", 64'(awready), 64'd1);
        chk("rel_wready", 64'(wready), 64'd1);
        chk("rel_arready", 64'(arready), 64'd1);

        // Table-driven single transactions
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr)
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp,
                          vecs[i].pulse, $sformatf("vec%0d", i));
            else
                axi_read(vecs[i].addr, vecs[i].rdata, vecs[i].resp, $sformatf("vec%0d", i));
        end
        chk("regout_w2", 64'(word(2)), 64'hDEADBEEF);
        chk("regout_ro3", 64'(word(3)), 64'd0);
        chk("regout_w15", 64'(word(15)), 64'h000000AA);

        // W arrives three cycles before AW, partial strobes
        awaddr = 32'h04; wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1'b1;
        tick();
        wvalid = 1'b0; wdata = '0; wstrb = '0;
        chk("split_wready_low", 64'(wready), 64'd0);
        chk("split_awready_high", 64'(awready), 64'd1);
        tick(); tick();
        chk("split_wready_still_low", 64'(wready), 64'd0);
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("split_pulse", 64'(wr_pulse), 64'h0002);
        tick();
        chk("split_bvalid", 64'(bvalid), 64'd1);
        chk("split_bresp", 64'(bresp), 64'd0);
        chk("split_reg1", 64'(word(1)), 64'hFF22FF44);
        bready = 1'b1; tick(); bready = 1'b0;
        chk("split_bvalid_drop", 64'(bvalid), 64'd0);

        // Read in the commit cycle sees the old value, the next read the new one
        awaddr = 32'h08; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h08; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("race_rvalid", 64'(rvalid), 64'd1);
        chk("race_old_data", 64'(rdata), 64'hDEADBEEF);
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        axi_read(32'h08, 32'h0BADF00D, 2'b00, "race_new");

        // Write response backpressure
        awaddr = 32'h0; wdata = 32'hCAFE0001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_bvalid%0d", c), 64'(bvalid), 64'd1);
            chk($sformatf("bp_bresp%0d", c), 64'(bresp), 64'd0);
            chk($sformatf("bp_awready%0d", c), 64'(awready), 64'd0);
            tick();
        end
        bready = 1'b1; tick(); bready = 1'b0;
        chk("bp_bvalid_drop", 64'(bvalid), 64'd0);
        chk("bp_reg0", 64'(word(0)), 64'hCAFE0001);

        // Read data backpressure
        araddr = 32'h08; arvalid = 1'b1;
        tick();
        arvalid = 1'b0; araddr = 32'h0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("rbp_rvalid%0d", c), 64'(rvalid), 64'd1);
            chk($sformatf("rbp_rdata%0d", c), 64'(rdata), 64'h0BADF00D);
            chk($sformatf("rbp_arready%0d", c), 64'(arready), 64'd0);
            tick();
        end
        rready = 1'b1; tick(); rready = 1'b0;
        chk("rbp_rvalid_drop", 64'(rvalid), 64'd0);

        // Reset while a write holds only its address and a read response is pending
        awaddr = 32'h10; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("mid_have_addr_awready", 64'(awready), 64'd0);
        chk("mid_have_addr_wready", 64'(wready), 64'd1);
        araddr = 32'h08; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("mid_rvalid_before", 64'(rvalid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
        chk("mid_rst_bvalid", 64'(bvalid), 64'd0);
        chk("mid_rst_awready", 64'(awready), 64'd0);
        chk("mid_rst_regout", 64'(reg_out == '0), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("mid_rel_awready", 64'(awready), 64'd1);
        chk("mid_rel_wready", 64'(wready), 64'd1);
        axi_write(32'h10, 32'h600DCAFE, 4'hF, 2'b00, 16'h0010, "post_rst_wr");
        axi_read(32'h10, 32'h600DCAFE, 2'b00, "post_rst_rd");
        axi_read(32'h08, 32'h0, 2'b00, "post_rst_cleared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
